// File: rtl/axis_arb_pkg.sv
// Shared types and width helpers for the AXI-Stream FIFO write arbiter.
// Width helpers take the module parameters because a package cannot see them.
package axis_arb_pkg;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_t;

  function automatic int grant_w(input int num_req);
    return (num_req > 1) ? $clog2(num_req) : 1;
  endfunction

  function automatic int beat_w(input int max_burst);
    return $clog2(max_burst) + 1;
  endfunction

endpackage

// File: rtl/rr_picker.sv
// Round-robin search: first set bit of req strictly after ptr, wrapping modulo N.
module rr_picker #(
  parameter int N     = 4,
  parameter int PTR_W = 2
) (
  input  logic [N-1:0]     req,
  input  logic [PTR_W-1:0] ptr,
  output logic             found,
  output logic [PTR_W-1:0] idx
);

  // Scan ptr+1 .. ptr+N so the last granted requester has the lowest priority
  always_comb begin
    int   pos_s;
    logic hit_s;
    found = 1'b0;
    idx   = '0;
    pos_s = 0;
    hit_s = 1'b0;
    for (int k = 1; k <= N; k++) begin
      pos_s = (int'(ptr) + k) % N;
      hit_s = (|(req & (N'(1) << pos_s))) & ~found;
      idx   = hit_s ? PTR_W'(pos_s) : idx;
      found = found | hit_s;
    end
  end

endmodule

// File: rtl/axis_fifo_arbiter.sv
// Round-robin arbiter merging NUM_REQ AXI-Stream requesters into one FIFO write port,
// with bounded bursts and a watermark stall on FIFO occupancy.
module axis_fifo_arbiter
  import axis_arb_pkg::*;
#(
  parameter int NUM_REQ     = 4,
  parameter int TDATA_WIDTH = 512,
  parameter int FIFO_DEPTH  = 512,
  parameter int MAX_BURST   = 16,
  parameter int HIGH_WM     = FIFO_DEPTH - 8
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic [NUM_REQ*TDATA_WIDTH-1:0]   s_axis_tdata,
  input  logic [NUM_REQ-1:0]               s_axis_tvalid,
  output logic [NUM_REQ-1:0]               s_axis_tready,
  output logic [TDATA_WIDTH-1:0]           m_axis_tdata,
  output logic                             m_axis_tvalid,
  input  logic                             m_axis_tready,
  input  logic [$clog2(FIFO_DEPTH):0]      fifo_wr_data_count,
  output logic [grant_w(NUM_REQ)-1:0]      grant_id,
  output logic                             busy
);

  localparam int GW = grant_w(NUM_REQ);
  localparam int BW = beat_w(MAX_BURST);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  arb_state_t    state_r, state_nxt_s;
  logic [GW-1:0] rr_ptr_r, rr_ptr_nxt_s;
  logic [GW-1:0] grant_id_r, grant_id_nxt_s;
  logic [GW-1:0] pick_idx_s;
  logic [BW-1:0] beat_cnt_r, beat_cnt_nxt_s;
  logic          pick_found_s;
  logic          throttle_s;
  logic          req_valid_s;
  logic          xfer_s;
  logic          last_beat_s;

  rr_picker #(
    .N     (NUM_REQ),
    .PTR_W (GW)
  ) u_picker (
    .req   (s_axis_tvalid),
    .ptr   (rr_ptr_r),
    .found (pick_found_s),
    .idx   (pick_idx_s)
  );

  // The watermark leaves headroom for beats already in flight past the count
  assign throttle_s  = (fifo_wr_data_count >= CW'(HIGH_WM));
  assign req_valid_s = s_axis_tvalid[grant_id_r];
  assign xfer_s      = m_axis_tvalid & m_axis_tready;
  assign last_beat_s = xfer_s & (beat_cnt_r == BW'(MAX_BURST - 1));
  assign grant_id    = grant_id_r;
  assign busy        = (state_r == GRANT);

  // Zero-latency pass-through of the granted requester; valid and ready share the throttle gate
  always_comb begin
    m_axis_tdata  = '0;
    m_axis_tvalid = 1'b0;
    s_axis_tready = '0;
    if (state_r == GRANT) begin
      m_axis_tdata                = s_axis_tdata[grant_id_r*TDATA_WIDTH +: TDATA_WIDTH];
      m_axis_tvalid               = req_valid_s & ~throttle_s;
      s_axis_tready[grant_id_r]   = m_axis_tready & ~throttle_s;
    end else begin
      m_axis_tdata  = '0;
      m_axis_tvalid = 1'b0;
      s_axis_tready = '0;
    end
  end

  // Arbitration in IDLE, burst bookkeeping and exit decision in GRANT
  always_comb begin
    state_nxt_s    = state_r;
    rr_ptr_nxt_s   = rr_ptr_r;
    grant_id_nxt_s = grant_id_r;
    beat_cnt_nxt_s = beat_cnt_r;
    case (state_r)
      IDLE: begin
        if (pick_found_s && !throttle_s) begin
          grant_id_nxt_s = pick_idx_s;
          beat_cnt_nxt_s = '0;
          state_nxt_s    = GRANT;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      GRANT: begin
        beat_cnt_nxt_s = beat_cnt_r + BW'(xfer_s);
        if (last_beat_s || !req_valid_s || throttle_s) begin
          state_nxt_s  = IDLE;
          rr_ptr_nxt_s = grant_id_r;
        end else begin
          state_nxt_s = GRANT;
        end
      end
      default: begin
        state_nxt_s = IDLE;
      end
    endcase
  end

  // State registers; reset parks the pointer on the last requester so requester 0 wins first
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= IDLE;
      rr_ptr_r   <= GW'(NUM_REQ - 1);
      grant_id_r <= '0;
      beat_cnt_r <= '0;
    end else begin
      state_r    <= state_nxt_s;
      rr_ptr_r   <= rr_ptr_nxt_s;
      grant_id_r <= grant_id_nxt_s;
      beat_cnt_r <= beat_cnt_nxt_s;
    end
  end

endmodule

// File: tb/tb_axis_fifo_arbiter.sv
// Scoreboard bench for axis_fifo_arbiter: tagged beats per requester, grant log per burst.
module tb_axis_fifo_arbiter;

  localparam int NR    = 4;
  localparam int W     = 32;
  localparam int DEPTH = 512;
  localparam int MB    = 16;
  localparam int WM    = DEPTH - 8;

  logic              clk;
  logic              rst_n;
  logic [NR*W-1:0]   s_data;
  logic [NR-1:0]     s_valid;
  logic [NR-1:0]     s_ready;
  logic [W-1:0]      m_data;
  logic              m_valid;
  logic              m_ready;
  logic [9:0]        fifo_cnt;
  logic [1:0]        grant_id;
  logic              busy;

  axis_fifo_arbiter #(
    .NUM_REQ     (NR),
    .TDATA_WIDTH (W),
    .FIFO_DEPTH  (DEPTH),
    .MAX_BURST   (MB)
  ) dut (
    .clk                (clk),
    .rst_n              (rst_n),
    .s_axis_tdata       (s_data),
    .s_axis_tvalid      (s_valid),
    .s_axis_tready      (s_ready),
    .m_axis_tdata       (m_data),
    .m_axis_tvalid      (m_valid),
    .m_axis_tready      (m_ready),
    .fifo_wr_data_count (fifo_cnt),
    .grant_id           (grant_id),
    .busy               (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  logic [31:0] src_q [NR][$];
  logic [31:0] exp_q [NR][$];
  int          seq [NR];
  logic        rand_ready;
  logic [9:0]  count_v;

  int   glog_id[$];
  int   glog_beats[$];
  int   glog_gap[$];
  int   cur_beats;
  int   cur_gid;
  int   idle_run;
  logic prev_busy;

  task automatic push_beats(input int r, input int n);
    logic [31:0] tag;
    for (int i = 0; i < n; i++) begin
      tag = (32'(r) << 24) | (32'(seq[r]) & 32'h00FF_FFFF);
      seq[r] = seq[r] + 1;
      src_q[r].push_back(tag);
      exp_q[r].push_back(tag);
    end
  endtask

  task automatic clear_logs();
    glog_id.delete();
    glog_beats.delete();
    glog_gap.delete();
  endtask

  function automatic bit all_empty();
    bit e;
    e = 1'b1;
    for (int i = 0; i < NR; i++) begin
      if (exp_q[i].size() != 0 || src_q[i].size() != 0) e = 1'b0;
    end
    return e;
  endfunction

  task automatic drive_inputs();
    for (int i = 0; i < NR; i++) begin
      if (src_q[i].size() > 0) begin
        s_valid[i]       = 1'b1;
        s_data[i*W +: W] = src_q[i][0];
      end else begin
        s_valid[i]       = 1'b0;
        s_data[i*W +: W] = '0;
      end
    end
    m_ready  = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    fifo_cnt = count_v;
  endtask

  task automatic sample();
    logic          thr;
    logic          exp_mv;
    logic [NR-1:0] exp_sr;
    logic [31:0]   exp_d;
    thr = (fifo_cnt >= 10'(WM));
    if (busy && !prev_busy) begin
      cur_beats = 0;
      cur_gid   = int'(grant_id);
      glog_gap.push_back(idle_run);
    end
    if (!busy && prev_busy) begin
      glog_id.push_back(cur_gid);
      glog_beats.push_back(cur_beats);
    end
    idle_run = busy ? 0 : idle_run + 1;
    if (busy) begin
      exp_mv = s_valid[grant_id] & ~thr;
      exp_sr = (m_ready & ~thr) ? (4'b0001 << grant_id) : 4'b0000;
    end else begin
      exp_mv = 1'b0;
      exp_sr = 4'b0000;
    end
    checks++;
    if (m_valid !== exp_mv || s_ready !== exp_sr) begin
      errors++;
      $display("FAIL handshake: got valid=%b ready=%b expected valid=%b ready=%b (grant %0d busy %b)",
               m_valid, s_ready, exp_mv, exp_sr, grant_id, busy);
    end
    if (m_valid && m_ready) begin
      checks++;
      if (exp_q[grant_id].size() == 0) begin
        errors++;
        $display("FAIL extra_beat: got %h expected no beat from requester %0d", m_data, grant_id);
      end else begin
        exp_d = exp_q[grant_id].pop_front();
        if (m_data !== exp_d) begin
          errors++;
          $display("FAIL beat_data: got %h expected %h", m_data, exp_d);
        end
      end
      cur_beats++;
    end
    for (int i = 0; i < NR; i++) begin
      if (s_valid[i] && s_ready[i] && src_q[i].size() > 0) void'(src_q[i].pop_front());
    end
    prev_busy = busy;
  endtask

  task automatic cycle();
    @(negedge clk);
    drive_inputs();
    #1;
    sample();
  endtask

  task automatic run_until_drained(input int budget);
    bit done;
    done = 1'b0;
    for (int c = 0; c < budget && !done; c++) begin
      cycle();
      if (all_empty() && !busy) done = 1'b1;
    end
    checks++;
    if (!done) begin
      errors++;
      $display("FAIL drain_timeout: got pending beats expected empty queues after %0d cycles", budget);
    end
  endtask

  task automatic wait_busy(input int budget);
    bit done;
    done = 1'b0;
    for (int c = 0; c < budget && !done; c++) begin
      cycle();
      if (busy) done = 1'b1;
    end
    checks++;
    if (!done) begin
      errors++;
      $display("FAIL busy_timeout: got busy=0 expected grant within %0d cycles", budget);
    end
  endtask

  task automatic check_log(input string name, input int ids[$], input int beats[$]);
    checks++;
    if (glog_id.size() != ids.size()) begin
      errors++;
      $display("FAIL %s_grants: got %0d grants expected %0d", name, glog_id.size(), ids.size());
    end else begin
      for (int k = 0; k < ids.size(); k++) begin
        checks++;
        if (glog_id[k] != ids[k] || glog_beats[k] != beats[k]) begin
          errors++;
          $display("FAIL %s_grant%0d: got id=%0d beats=%0d expected id=%0d beats=%0d",
                   name, k, glog_id[k], glog_beats[k], ids[k], beats[k]);
        end
      end
    end
  endtask

  task automatic test_reset();
    rst_n   = 1'b0;
    s_valid = 4'hF;
    s_data  = '1;
    m_ready = 1'b1;
    fifo_cnt = '0;
    repeat (3) @(negedge clk);
    #1;
    checks++;
    if (m_valid !== 1'b0 || s_ready !== 4'h0 || busy !== 1'b0 || grant_id !== 2'd0) begin
      errors++;
      $display("FAIL reset_state: got valid=%b ready=%b busy=%b grant=%0d expected 0 0 0 0",
               m_valid, s_ready, busy, grant_id);
    end
    s_valid = '0;
    s_data  = '0;
    rst_n   = 1'b1;
    cycle();
    cycle();
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_idle: got busy=%b expected 0 with no requesters", busy);
    end
  endtask

  task automatic test_round_robin();
    clear_logs();
    push_beats(0, 48);
    push_beats(2, 48);
    run_until_drained(300);
    check_log("rr", '{0, 2, 0, 2, 0, 2}, '{16, 16, 16, 16, 16, 16});
    for (int k = 1; k < glog_gap.size(); k++) begin
      checks++;
      if (glog_gap[k] != 1) begin
        errors++;
        $display("FAIL rr_bubble%0d: got %0d idle cycles expected 1", k, glog_gap[k]);
      end
    end
  endtask

  task automatic test_drop_valid();
    clear_logs();
    push_beats(1, 5);
    wait_busy(20);
    push_beats(2, 4);
    push_beats(3, 4);
    push_beats(0, 4);
    run_until_drained(200);
    check_log("drop_a", '{1, 2, 3, 0}, '{5, 4, 4, 4});
    clear_logs();
    push_beats(1, 5);
    wait_busy(20);
    push_beats(3, 3);
    push_beats(0, 3);
    run_until_drained(200);
    check_log("drop_b", '{1, 3, 0}, '{5, 3, 3});
  endtask

  task automatic test_throttle();
    bit got;
    clear_logs();
    push_beats(0, 20);
    got = 1'b0;
    for (int c = 0; c < 30 && !got; c++) begin
      cycle();
      if (busy && cur_beats == 3) got = 1'b1;
    end
    count_v = 10'(WM);
    cycle();
    checks++;
    if (busy !== 1'b1 || m_valid !== 1'b0 || s_ready !== 4'h0) begin
      errors++;
      $display("FAIL throttle_gate: got busy=%b valid=%b ready=%b expected 1 0 0", busy, m_valid, s_ready);
    end
    for (int c = 0; c < 5; c++) begin
      cycle();
      checks++;
      if (busy !== 1'b0) begin
        errors++;
        $display("FAIL throttle_hold%0d: got busy=%b expected 0 at count %0d", c, busy, count_v);
      end
    end
    count_v = 10'(WM - 1);
    cycle();
    cycle();
    checks++;
    if (busy !== 1'b1 || grant_id !== 2'd0) begin
      errors++;
      $display("FAIL throttle_release: got busy=%b grant=%0d expected busy=1 grant=0", busy, grant_id);
    end
    count_v = '0;
    run_until_drained(200);
    check_log("throttle", '{0, 0, 0}, '{3, 16, 1});
  endtask

  task automatic test_random_ready();
    int total;
    clear_logs();
    rand_ready = 1'b1;
    for (int r = 0; r < NR; r++) push_beats(r, 40);
    run_until_drained(3000);
    rand_ready = 1'b0;
    total = 0;
    for (int k = 0; k < glog_beats.size(); k++) begin
      total += glog_beats[k];
      checks++;
      if (glog_beats[k] > MB || glog_beats[k] < 1) begin
        errors++;
        $display("FAIL rand_burst%0d: got %0d beats expected 1..%0d", k, glog_beats[k], MB);
      end
    end
    checks++;
    if (total != 4 * 40) begin
      errors++;
      $display("FAIL rand_total: got %0d beats expected %0d", total, 4 * 40);
    end
  endtask

  task automatic test_reset_mid_burst();
    bit got;
    clear_logs();
    push_beats(3, 20);
    got = 1'b0;
    for (int c = 0; c < 40 && !got; c++) begin
      cycle();
      if (busy && cur_beats == 6) got = 1'b1;
    end
    @(negedge clk);
    drive_inputs();
    #1;
    checks++;
    if (m_valid !== 1'b1 || grant_id !== 2'd3) begin
      errors++;
      $display("FAIL beat7_present: got valid=%b grant=%0d expected valid=1 grant=3", m_valid, grant_id);
    end
    #1 rst_n = 1'b0;
    #1;
    checks++;
    if (m_valid !== 1'b0 || s_ready !== 4'h0 || busy !== 1'b0 || grant_id !== 2'd0 || m_data !== '0) begin
      errors++;
      $display("FAIL async_reset: got valid=%b ready=%b busy=%b grant=%0d data=%h expected all 0",
               m_valid, s_ready, busy, grant_id, m_data);
    end
    @(posedge clk);
    #1;
    checks++;
    if (busy !== 1'b0 || m_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_hold: got busy=%b valid=%b expected 0 0", busy, m_valid);
    end
    prev_busy = 1'b0;
    idle_run  = 0;
    clear_logs();
    push_beats(0, 4);
    drive_inputs();
    rst_n = 1'b1;
    run_until_drained(200);
    check_log("post_reset", '{0, 3}, '{4, 14});
  endtask

  initial begin
    rand_ready = 1'b0;
    count_v    = '0;
    cur_beats  = 0;
    cur_gid    = 0;
    idle_run   = 0;
    prev_busy  = 1'b0;
    for (int i = 0; i < NR; i++) seq[i] = 0;
    test_reset();
    test_round_robin();
    test_drop_valid();
    test_throttle();
    test_random_ready();
    test_reset_mid_burst();
    checks++;
    if (!all_empty()) begin
      errors++;
      $display("FAIL final_empty: got leftover beats expected none");
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
